// File: rtl/ysyx_22040386_pc_redirect_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040386_pc_redirect_pkg
// Shared definitions for the fetch-PC redirect block:
//   - state_e          : BOOT / RUN / TRAP encodings (2 bits)
//   - CAUSE_ECALL_M    : mcause for an environment call from M-mode (11)
//   - CAUSE_IMISALIGN  : mcause for an instruction-address-misaligned trap (0)
//   - DEFAULT_RESET_PC : first fetch address after reset
// ---------------------------------------------------------------------------
package ysyx_22040386_pc_redirect_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  localparam int unsigned   CAUSE_ECALL_M    = 11;
  localparam int unsigned   CAUSE_IMISALIGN  = 0;
  localparam logic [63:0]   DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22040386_pc_redirect_target_sel.sv
// ---------------------------------------------------------------------------
// ysyx_22040386_pc_redirect_target_sel
// Combinational priority mux for the control-flow decision coming out of EX.
// Priority: ecall > mret > jalr > branch. Only the winning flag acts.
//
// Ports:
//   ex_valid, ecall, mret, jalr, branch : resolved instruction and its flags
//   ex_pc, ex_imm                       : branch/jal base and offset
//   jalr_target                         : rs1+imm for jalr
//   csr_mepc                            : mret return address
//   redirect : some flag acts this cycle (trap or plain redirect)
//   is_trap  : the action is a trap entry rather than a PC redirect
//   is_mret  : the action is a committed mret
//   target   : new fetch address for a non-trap redirect (word aligned)
//   cause    : mcause value when is_trap is set
//
// Configuration macro: YSYX_22040386_MISALIGN_CHK_EN
//   defined   - a misaligned non-trap target raises an instruction-address-
//               misaligned trap instead of redirecting
//   undefined - target[1:0] is cleared and no check is made
// ---------------------------------------------------------------------------
module ysyx_22040386_pc_redirect_target_sel
  import ysyx_22040386_pc_redirect_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            ex_valid,
  input  logic            ecall,
  input  logic            mret,
  input  logic            jalr,
  input  logic            branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            redirect,
  output logic            is_trap,
  output logic            is_mret,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] cause
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    redirect   = 1'b0;
    is_trap    = 1'b0;
    is_mret    = 1'b0;
    raw_target = '0;
    cause      = '0;

    if (ex_valid) begin
      if (ecall) begin
        redirect = 1'b1;
        is_trap  = 1'b1;
        cause    = XLEN'(CAUSE_ECALL_M);
      end else if (mret) begin
        redirect   = 1'b1;
        is_mret    = 1'b1;
        raw_target = csr_mepc;
      end else if (jalr) begin
        redirect   = 1'b1;
        raw_target = jalr_target & ~XLEN'(1);
      end else if (branch) begin
        redirect   = 1'b1;
        raw_target = ex_pc + ex_imm;
      end
    end

`ifdef YSYX_22040386_MISALIGN_CHK_EN
    target = raw_target;
    // A misaligned mret/jalr/branch target becomes a trap; the mret is not
    // committed because the CSR side effects must not happen.
    if (redirect && !is_trap && (raw_target[1:0] != 2'b00)) begin
      is_trap = 1'b1;
      is_mret = 1'b0;
      cause   = XLEN'(CAUSE_IMISALIGN);
    end
`else
    target = raw_target & ~XLEN'(3);
`endif
  end

endmodule

// File: rtl/ysyx_22040386_pc_redirect.sv
// ---------------------------------------------------------------------------
// ysyx_22040386_pc_redirect
// Owns the fetch PC. Streams word-sequential fetch requests to the IFU,
// redirects on taken control flow resolved in EX, flushes younger IF/ID work
// and sequences the trap hand-off to the CSR file.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   ex_*, branch, jalr,
//   ecall, mret,
//   jalr_target           : resolved instruction from EX
//   csr_mtvec, csr_mepc   : trap vector / return address from the CSR file
//   if_ready / if_valid,
//   if_pc                 : valid/ready fetch request stream to the IFU
//   flush                 : one-cycle pulse killing younger IF/ID work
//   trap_valid/trap_ready,
//   trap_epc, trap_cause  : trap request to the CSR file (held until ready)
//   mret_commit           : one-cycle pulse, CSR restores mstatus
//
// Configuration macro: YSYX_22040386_MISALIGN_CHK_EN (see target_sel).
// ---------------------------------------------------------------------------
module ysyx_22040386_pc_redirect
  import ysyx_22040386_pc_redirect_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            branch,
  input  logic            jalr,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic            flush,
  output logic            trap_valid,
  input  logic            trap_ready,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_cause,
  output logic            mret_commit
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            mret_commit_q, mret_commit_d;
  logic            trap_valid_q, trap_valid_d;
  logic [XLEN-1:0] trap_epc_q, trap_epc_d;
  logic [XLEN-1:0] trap_cause_q, trap_cause_d;

  logic            sel_redirect;
  logic            sel_is_trap;
  logic            sel_is_mret;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] sel_cause;

  ysyx_22040386_pc_redirect_target_sel #(
    .XLEN (XLEN)
  ) u_target_sel (
    .ex_valid    (ex_valid),
    .ecall       (ecall),
    .mret        (mret),
    .jalr        (jalr),
    .branch      (branch),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .jalr_target (jalr_target),
    .csr_mepc    (csr_mepc),
    .redirect    (sel_redirect),
    .is_trap     (sel_is_trap),
    .is_mret     (sel_is_mret),
    .target      (sel_target),
    .cause       (sel_cause)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = 1'b0;
    mret_commit_d = 1'b0;
    trap_valid_d  = trap_valid_q;
    trap_epc_d    = trap_epc_q;
    trap_cause_d  = trap_cause_q;

    unique case (state_q)
      ST_BOOT: begin
        // EX is ignored here; fetch starts from RESET_PC next cycle.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (sel_redirect && sel_is_trap) begin
          state_d      = ST_TRAP;
          trap_valid_d = 1'b1;
          trap_epc_d   = ex_pc;
          trap_cause_d = sel_cause;
          flush_d      = 1'b1;
        end else if (sel_redirect) begin
          // Overrides both the +4 step and any request still waiting on
          // if_ready; the flush kills whatever was in flight.
          pc_d          = sel_target;
          flush_d       = 1'b1;
          mret_commit_d = sel_is_mret;
        end else if (if_ready) begin
          pc_d = pc_q + XLEN'(4);
        end
      end

      ST_TRAP: begin
        if (trap_ready) begin
          state_d      = ST_RUN;
          pc_d         = csr_mtvec & ~XLEN'(3);
          trap_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      mret_commit_q <= 1'b0;
      trap_valid_q  <= 1'b0;
      trap_epc_q    <= '0;
      trap_cause_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      mret_commit_q <= mret_commit_d;
      trap_valid_q  <= trap_valid_d;
      trap_epc_q    <= trap_epc_d;
      trap_cause_q  <= trap_cause_d;
    end
  end

  assign if_valid    = (state_q == ST_RUN);
  assign if_pc       = pc_q;
  assign flush       = flush_q;
  assign mret_commit = mret_commit_q;
  assign trap_valid  = trap_valid_q;
  assign trap_epc    = trap_epc_q;
  assign trap_cause  = trap_cause_q;

endmodule

// File: tb/tb_ysyx_22040386_pc_redirect.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040386_pc_redirect
// Directed scenarios with literal expectations followed by randomized
// traffic, all checked every cycle against a behavioural model of the
// fetch-PC / trap rules.
// ---------------------------------------------------------------------------
module tb_ysyx_22040386_pc_redirect;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [63:0] ex_imm;
  logic        branch, jalr, ecall, mret;
  logic [63:0] jalr_target, csr_mtvec, csr_mepc;
  logic        if_ready;
  logic        if_valid;
  logic [63:0] if_pc;
  logic        flush;
  logic        trap_valid;
  logic        trap_ready;
  logic [63:0] trap_epc, trap_cause;
  logic        mret_commit;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ysyx_22040386_pc_redirect dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .branch      (branch),
    .jalr        (jalr),
    .ecall       (ecall),
    .mret        (mret),
    .jalr_target (jalr_target),
    .csr_mtvec   (csr_mtvec),
    .csr_mepc    (csr_mepc),
    .if_ready    (if_ready),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .flush       (flush),
    .trap_valid  (trap_valid),
    .trap_ready  (trap_ready),
    .trap_epc    (trap_epc),
    .trap_cause  (trap_cause),
    .mret_commit (mret_commit)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting to start fetch, 1 = fetching, 2 = trap pending
  int          m_mode;
  logic [63:0] m_pc, m_epc, m_cause;
  logic        m_flush, m_tv, m_mret;

  function automatic logic [63:0] f_target(input logic is_m, input logic is_j,
                                           input logic [63:0] mepc, input logic [63:0] jt,
                                           input logic [63:0] pc, input logic [63:0] imm);
    if (is_m)      return mepc;
    else if (is_j) return jt & ~64'd1;
    else           return pc + imm;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_pc <= RST_PC; m_flush <= 1'b0; m_tv <= 1'b0;
      m_epc <= '0; m_cause <= '0; m_mret <= 1'b0;
    end else begin
      m_flush <= 1'b0;
      m_mret  <= 1'b0;
      if (m_mode == 0) begin
        m_mode <= 1;
      end else if (m_mode == 1) begin
        if (ex_valid && ecall) begin
          m_mode <= 2; m_tv <= 1'b1; m_epc <= ex_pc; m_cause <= 64'd11; m_flush <= 1'b1;
        end else if (ex_valid && (mret || jalr || branch)) begin
`ifdef YSYX_22040386_MISALIGN_CHK_EN
          if ((f_target(mret, jalr, csr_mepc, jalr_target, ex_pc, ex_imm) & 64'd3) != 0) begin
            m_mode <= 2; m_tv <= 1'b1; m_epc <= ex_pc; m_cause <= 64'd0; m_flush <= 1'b1;
          end else begin
            m_pc <= f_target(mret, jalr, csr_mepc, jalr_target, ex_pc, ex_imm);
            m_flush <= 1'b1; m_mret <= mret;
          end
`else
          m_pc <= f_target(mret, jalr, csr_mepc, jalr_target, ex_pc, ex_imm) & ~64'd3;
          m_flush <= 1'b1; m_mret <= mret;
`endif
        end else if (if_ready) begin
          m_pc <= m_pc + 64'd4;
        end
      end else if (trap_ready) begin
        m_mode <= 1; m_pc <= csr_mtvec & ~64'd3; m_tv <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_if_valid", {63'd0, if_valid}, {63'd0, m_mode == 1});
      chk("cyc_flush", {63'd0, flush}, {63'd0, m_flush});
      chk("cyc_trap_valid", {63'd0, trap_valid}, {63'd0, m_tv});
      chk("cyc_mret_commit", {63'd0, mret_commit}, {63'd0, m_mret});
      if (m_mode != 2) chk("cyc_if_pc", if_pc, m_pc);
      if (m_tv || m_mode == 0) begin
        chk("cyc_trap_epc", trap_epc, m_epc);
        chk("cyc_trap_cause", trap_cause, m_cause);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid = 0; branch = 0; jalr = 0; ecall = 0; mret = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clr_ex();
    ex_pc = '0; ex_imm = '0; jalr_target = '0; csr_mtvec = '0; csr_mepc = '0;
    if_ready = 1; trap_ready = 0;

    // Reset state
    tick(); chk_en = 1'b1;
    tick();
    chk("rst_if_pc", if_pc, RST_PC);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_trap_valid", {63'd0, trap_valid}, 64'd0);
    chk("rst_trap_epc", trap_epc, 64'd0);
    chk("rst_trap_cause", trap_cause, 64'd0);
    chk("rst_mret", {63'd0, mret_commit}, 64'd0);

    // 1. Sequential fetch
    rst = 0;
    tick(); chk("seq_pc0", if_pc, 64'h8000_0000); chk("seq_valid", {63'd0, if_valid}, 64'd1);
    tick(); chk("seq_pc1", if_pc, 64'h8000_0004);
    tick(); chk("seq_pc2", if_pc, 64'h8000_0008); chk("seq_flush", {63'd0, flush}, 64'd0);

    // 2. Back-pressure holds the request
    if_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_pc", if_pc, 64'h8000_0008);
    end
    if_ready = 1;
    tick(); chk("stall_release_pc", if_pc, 64'h8000_000C);

    // 3. Taken branch with negative offset
    ex_valid = 1; branch = 1; ex_pc = 64'h8000_0010; ex_imm = -64'sd16;
    tick(); chk("br_pc", if_pc, 64'h8000_0000); chk("br_flush", {63'd0, flush}, 64'd1);
    clr_ex();
    tick(); chk("br_flush_off", {63'd0, flush}, 64'd0); chk("br_pc_next", if_pc, 64'h8000_0004);

    // 4. ecall wins over jalr; trap held until trap_ready
    ex_valid = 1; ecall = 1; jalr = 1; ex_pc = 64'h8000_0020; jalr_target = 64'h9000_0000;
    csr_mtvec = 64'h8000_0101;
    tick();
    chk("trap_flush", {63'd0, flush}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("trap_valid", {63'd0, trap_valid}, 64'd1);
      chk("trap_epc", trap_epc, 64'h8000_0020);
      chk("trap_cause", trap_cause, 64'd11);
      chk("trap_if_valid", {63'd0, if_valid}, 64'd0);
      // EX activity during TRAP must be ignored
      clr_ex(); ex_valid = 1; branch = 1; ex_imm = 64'h40;
      if (i == 3) trap_ready = 1;
    end
    clr_ex();
    tick(); trap_ready = 0;
    chk("trap_exit_pc", if_pc, 64'h8000_0100);
    chk("trap_exit_tv", {63'd0, trap_valid}, 64'd0);
    chk("trap_exit_valid", {63'd0, if_valid}, 64'd1);

    // 5. mret
    ex_valid = 1; mret = 1; csr_mepc = 64'h8000_0024;
    tick();
    chk("mret_pc", if_pc, 64'h8000_0024);
    chk("mret_commit", {63'd0, mret_commit}, 64'd1);
    chk("mret_flush", {63'd0, flush}, 64'd1);
    clr_ex();
    tick(); chk("mret_commit_off", {63'd0, mret_commit}, 64'd0);

    // 6. Reset mid-TRAP drops the trap
    ex_valid = 1; ecall = 1; ex_pc = 64'h8000_0030;
    tick(); clr_ex(); chk("trap2_valid", {63'd0, trap_valid}, 64'd1);
    tick();
    rst = 1;
    tick();
    chk("midtrap_rst_tv", {63'd0, trap_valid}, 64'd0);
    chk("midtrap_rst_pc", if_pc, RST_PC);
    rst = 0;
    tick();
    ex_valid = 1; jalr = 1; ex_pc = 64'h8000_0040; jalr_target = 64'h8000_0002;
    tick(); clr_ex();
`ifdef YSYX_22040386_MISALIGN_CHK_EN
    chk("misalign_tv", {63'd0, trap_valid}, 64'd1);
    chk("misalign_cause", trap_cause, 64'd0);
    chk("misalign_epc", trap_epc, 64'h8000_0040);
    trap_ready = 1; tick(); trap_ready = 0;
`else
    chk("misalign_pc", if_pc, 64'h8000_0000);
    chk("misalign_flush", {63'd0, flush}, 64'd1);
`endif

    // Randomized traffic, checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(63) == 0);
      ex_valid    = $urandom_range(1);
      branch      = ($urandom_range(3) == 0);
      jalr        = ($urandom_range(3) == 0);
      ecall       = ($urandom_range(7) == 0);
      mret        = ($urandom_range(5) == 0);
      ex_pc       = {$urandom, $urandom};
      ex_imm      = {{52{1'b0}}, 12'($urandom)} - 64'd2048;
      jalr_target = {$urandom, $urandom};
      csr_mtvec   = {$urandom, $urandom};
      csr_mepc    = {$urandom, $urandom};
      if_ready    = ($urandom_range(3) != 0);
      trap_ready  = ($urandom_range(2) == 0);
      tick();
    end
    rst = 0; clr_ex();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
